mod_multiplier_barrett64: RTL and testbench



---
 rtl/mod_multiplier_barrett64.sv | 161 ++++++++++++++++
 tb/tb_mod_multiplier_barrett64.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mod_multiplier_barrett64.sv
// mod_multiplier_barrett64: 10-stage pipelined (a*b) mod m using Barrett reduction (k = 64).
// m and u travel down the pipe with their operands, so every in-flight op is self-consistent.
module mod_multiplier_barrett64 (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iEn,
  input  logic         iClr,
  input  logic [127:0] iU,
  input  logic [63:0]  iData0,
  input  logic [63:0]  iData1,
  input  logic [63:0]  iMod,
  output logic [63:0]  oData
);

  // S1: operand capture
  logic [63:0]  a1_q, b1_q, m1_q;
  logic [64:0]  u1_q;
  // S2: 32x32 partial products of a*b
  logic [63:0]  pll2_q, plh2_q, phl2_q, phh2_q, m2_q;
  logic [63:0]  pll2_d, plh2_d, phl2_d, phh2_d;
  logic [64:0]  u2_q;
  // S3: full product x
  logic [127:0] x3_q, x3_d;
  logic [63:0]  m3_q;
  logic [64:0]  u3_q;
  // S4: q1 = x >> 63; only x mod 2^66 is needed past this point
  logic [64:0]  q1_4_q, q1_4_d, u4_q;
  logic [65:0]  x4_q, x4_d;
  logic [63:0]  m4_q;
  // S5: q1*u split on u[31:0] / u[64:32]
  logic [96:0]  qul5_q, qul5_d;
  logic [97:0]  quh5_q, quh5_d;
  logic [65:0]  x5_q;
  logic [63:0]  m5_q;
  // S6: q3 = (q1*u) >> 65
  logic [129:0] q2;
  logic [64:0]  q3_6_q, q3_6_d;
  logic [65:0]  x6_q;
  logic [63:0]  m6_q;
  // S7: q3*m mod 2^66, split on m[31:0] / m[63:32]
  logic [65:0]  qml7_q, qml7_d;
  logic [33:0]  qmh7_q, qmh7_d;
  logic [65:0]  x7_q;
  logic [63:0]  m7_q;
  // S8: q3*m mod 2^66
  logic [65:0]  qm8_q, qm8_d, x8_q;
  logic [63:0]  m8_q;
  // S9: r = x - q3*m, 0 <= r < 3m
  logic [65:0]  r9_q, r9_d;
  logic [63:0]  m9_q;
  // S10: two conditional subtractions
  logic [65:0]  r1, r2;
  logic [63:0]  odata_q, odata_d;

  logic         unused_bits;

  always_comb begin
    pll2_d = {32'd0, a1_q[31:0]}  * {32'd0, b1_q[31:0]};
    plh2_d = {32'd0, a1_q[31:0]}  * {32'd0, b1_q[63:32]};
    phl2_d = {32'd0, a1_q[63:32]} * {32'd0, b1_q[31:0]};
    phh2_d = {32'd0, a1_q[63:32]} * {32'd0, b1_q[63:32]};

    x3_d = {64'd0, pll2_q} + {32'd0, plh2_q, 32'd0} + {32'd0, phl2_q, 32'd0} + {phh2_q, 64'd0};

    q1_4_d = x3_q[127:63];
    x4_d   = x3_q[65:0];

    qul5_d = {32'd0, q1_4_q} * {65'd0, u4_q[31:0]};
    quh5_d = {33'd0, q1_4_q} * {65'd0, u4_q[64:32]};

    q2     = {33'd0, qul5_q} + {quh5_q, 32'd0};
    q3_6_d = q2[129:65];

    // Only the low 66 bits of q3*m matter since r < 3m < 2^66.
    qml7_d = {1'b0, q3_6_q} * {34'd0, m6_q[31:0]};
    qmh7_d = q3_6_q[33:0] * {2'd0, m6_q[63:32]};

    qm8_d = qml7_q + {qmh7_q, 32'd0};

    r9_d = x8_q - qm8_q;

    r1      = (r9_q >= {2'd0, m9_q}) ? (r9_q - {2'd0, m9_q}) : r9_q;
    r2      = (r1 >= {2'd0, m9_q}) ? (r1 - {2'd0, m9_q}) : r1;
    odata_d = r2[63:0];
  end

  assign unused_bits = ^{iU[127:65], q2[64:0], r2[65:64]};

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      a1_q    <= '0; b1_q <= '0; m1_q <= '0; u1_q <= '0;
      pll2_q  <= '0; plh2_q <= '0; phl2_q <= '0; phh2_q <= '0; m2_q <= '0; u2_q <= '0;
      x3_q    <= '0; m3_q <= '0; u3_q <= '0;
      q1_4_q  <= '0; x4_q <= '0; m4_q <= '0; u4_q <= '0;
      qul5_q  <= '0; quh5_q <= '0; x5_q <= '0; m5_q <= '0;
      q3_6_q  <= '0; x6_q <= '0; m6_q <= '0;
      qml7_q  <= '0; qmh7_q <= '0; x7_q <= '0; m7_q <= '0;
      qm8_q   <= '0; x8_q <= '0; m8_q <= '0;
      r9_q    <= '0; m9_q <= '0;
      odata_q <= '0;
    end else if (iClr) begin
      a1_q    <= '0; b1_q <= '0; m1_q <= '0; u1_q <= '0;
      pll2_q  <= '0; plh2_q <= '0; phl2_q <= '0; phh2_q <= '0; m2_q <= '0; u2_q <= '0;
      x3_q    <= '0; m3_q <= '0; u3_q <= '0;
      q1_4_q  <= '0; x4_q <= '0; m4_q <= '0; u4_q <= '0;
      qul5_q  <= '0; quh5_q <= '0; x5_q <= '0; m5_q <= '0;
      q3_6_q  <= '0; x6_q <= '0; m6_q <= '0;
      qml7_q  <= '0; qmh7_q <= '0; x7_q <= '0; m7_q <= '0;
      qm8_q   <= '0; x8_q <= '0; m8_q <= '0;
      r9_q    <= '0; m9_q <= '0;
      odata_q <= '0;
    end else if (iEn) begin
      a1_q    <= iData0;
      b1_q    <= iData1;
      m1_q    <= iMod;
      u1_q    <= iU[64:0];

      pll2_q  <= pll2_d;
      plh2_q  <= plh2_d;
      phl2_q  <= phl2_d;
      phh2_q  <= phh2_d;
      m2_q    <= m1_q;
      u2_q    <= u1_q;

      x3_q    <= x3_d;
      m3_q    <= m2_q;
      u3_q    <= u2_q;

      q1_4_q  <= q1_4_d;
      x4_q    <= x4_d;
      m4_q    <= m3_q;
      u4_q    <= u3_q;

      qul5_q  <= qul5_d;
      quh5_q  <= quh5_d;
      x5_q    <= x4_q;
      m5_q    <= m4_q;

      q3_6_q  <= q3_6_d;
      x6_q    <= x5_q;
      m6_q    <= m5_q;

      qml7_q  <= qml7_d;
      qmh7_q  <= qmh7_d;
      x7_q    <= x6_q;
      m7_q    <= m6_q;

      qm8_q   <= qm8_d;
      x8_q    <= x7_q;
      m8_q    <= m7_q;

      r9_q    <= r9_d;
      m9_q    <= m8_q;

      odata_q <= odata_d;
    end
  end

  assign oData = odata_q;

endmodule

// File: tb/tb_mod_multiplier_barrett64.sv
// Directed and streaming bench for mod_multiplier_barrett64 against a 10-deep delayed golden model.
module tb_mod_multiplier_barrett64;

  logic         iClk, iRstN, iEn, iClr;
  logic [127:0] iU;
  logic [63:0]  iData0, iData1, iMod, oData;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl [10];

  localparam logic [63:0]  M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] U1 = 128'h1_0000_0000_0000_0001;

  mod_multiplier_barrett64 dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iU     (iU),
    .iData0 (iData0),
    .iData1 (iData1),
    .iMod   (iMod),
    .oData  (oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] calc_u(input logic [63:0] m);
    logic [129:0] num;
    logic [129:0] q;
    num = 130'd1 << 128;
    q   = num / {66'd0, m};
    return q[127:0];
  endfunction

  function automatic logic [63:0] golden(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
    logic [127:0] x;
    logic [127:0] r;
    x = {64'd0, a} * {64'd0, b};
    r = x % {64'd0, m};
    return r[63:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] m, input logic [127:0] u, input string tag);
    iEn = en; iClr = clr; iData0 = a; iData1 = b; iMod = m; iU = u;
    @(posedge iClk);
    #1;
    if (clr) begin
      for (int i = 0; i < 10; i++) mdl[i] = '0;
    end else if (en) begin
      for (int i = 9; i > 0; i--) mdl[i] = mdl[i-1];
      mdl[0] = golden(a, b, m);
    end
    check(tag, oData, mdl[9]);
  endtask

  initial begin
    logic [63:0]  da [6];
    logic [63:0]  db [6];
    logic [63:0]  dm [6];
    logic [63:0]  dx [6];
    logic [127:0] du [6];
    logic [63:0]  a, b, m;
    logic [127:0] ut, junk;

    for (int i = 0; i < 10; i++) mdl[i] = '0;

    // Reset held with random inputs
    iRstN = 1'b0; iEn = 1'b1; iClr = 1'b0;
    iData0 = rand64(); iData1 = rand64(); iMod = rand64(); iU = {rand64(), rand64()};
    #1;
    check("reset_async", oData, 64'd0);
    for (int i = 0; i < 3; i++) begin
      iData0 = rand64(); iData1 = rand64(); iMod = rand64();
      @(posedge iClk);
      #1;
      check("reset_hold", oData, 64'd0);
    end
    iRstN = 1'b1;

    // Directed vectors with hand-computed results
    da[0] = 64'd3;        db[0] = 64'd5;        dm[0] = M1; du[0] = U1; dx[0] = 64'd15;
    da[1] = M1 - 64'd1;   db[1] = M1 - 64'd1;   dm[1] = M1; du[1] = U1; dx[1] = 64'd1;
    da[2] = M1;           db[2] = 64'd12345;    dm[2] = M1; du[2] = U1; dx[2] = 64'd0;
    da[3] = 64'd0;        db[3] = rand64();     dm[3] = M1; du[3] = U1; dx[3] = 64'd0;
    da[4] = 64'h1_0000_0000; db[4] = 64'h1_0000_0000;
    dm[4] = 64'hFFFF_FFFF_0000_0001; du[4] = calc_u(dm[4]); dx[4] = 64'hFFFF_FFFF;
    da[5] = 64'h1_0000_0000; db[5] = 64'h1_0000_0000;
    dm[5] = 64'hFFFF_FFFF_FFFF_FFC5; du[5] = calc_u(dm[5]); dx[5] = 64'd59;

    for (int i = 0; i < 15; i++) begin
      if (i < 6) step(1'b1, 1'b0, da[i], db[i], dm[i], du[i], "directed_pipe");
      else       step(1'b1, 1'b0, 64'd0, 64'd0, M1, U1, "directed_pipe");
      if (i >= 9) check("directed_result", oData, dx[i-9]);
    end

    // Streaming, fixed modulus, 32-bit operands
    for (int i = 0; i < 100; i++) begin
      a = {32'd0, $urandom()};
      b = {32'd0, $urandom()};
      step(1'b1, 1'b0, a, b, M1, U1, "stream32");
    end

    // Streaming, random 64-bit operands and per-cycle modulus, with stall and clears
    for (int i = 0; i < 100; i++) begin
      if (i == 40) begin
        for (int s = 0; s < 3; s++)
          step(1'b0, 1'b0, rand64(), rand64(), rand64(), {rand64(), rand64()}, "stall_hold");
      end
      if (i == 70) begin
        step(1'b1, 1'b1, rand64(), rand64(), rand64(), {rand64(), rand64()}, "clear");
        check("clear_zero", oData, 64'd0);
      end
      if (i == 85) begin
        step(1'b0, 1'b1, rand64(), rand64(), rand64(), {rand64(), rand64()}, "clear_noen");
        check("clear_noen_zero", oData, 64'd0);
      end
      a = rand64();
      b = rand64();
      m = rand64();
      m[63] = 1'b1;
      if (m == 64'h8000_0000_0000_0000) m[0] = 1'b1;
      ut   = calc_u(m);
      junk = {rand64(), rand64()};
      step(1'b1, 1'b0, a, b, m, {junk[127:65], ut[64:0]}, "stream64");
    end

    // Asynchronous reset mid-stream
    iRstN = 1'b0;
    #2;
    for (int i = 0; i < 10; i++) mdl[i] = '0;
    check("reset_mid_async", oData, 64'd0);
    @(posedge iClk);
    #1;
    check("reset_mid_hold", oData, 64'd0);
    #2;
    iRstN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = rand64();
      b = rand64();
      step(1'b1, 1'b0, a, b, M1, U1, "post_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
